// File: rtl/video_pkg.sv
// Shared constants, FSM encoding and helpers for the video line fetcher.
package video_pkg;
  localparam int MAX_WORDS = 384;
  localparam int ADDR_W    = 21;
  localparam int CNT_W     = 9;
  localparam int ACT_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [CNT_W-1:0] clamp_words(input logic [CNT_W-1:0] words,
                                                    input int max_words);
    return (int'(words) > max_words) ? CNT_W'(max_words) : words;
  endfunction
endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module line_ram #(
  parameter int DEPTH = 768,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/video_line_fetch.sv
// Double-buffered scanline fetcher: fills the back bank from memory while the
// front bank is streamed out as 8-bit CLUT indices.
module video_line_fetch
  import video_pkg::*;
#(
  parameter int MAX_WORDS = video_pkg::MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_line,
  input  logic              hblank,
  input  logic              cm,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  line_words,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        pix,
  output logic              pix_valid,
  output logic              underrun,
  output fetch_state_t      o_dbg_state
);
  localparam int RAM_D  = 2 * MAX_WORDS;
  localparam int RAM_AW = $clog2(RAM_D);

  // Memory handshake: mem_req/mem_addr stay stable until the cycle mem_ack is
  // high; that cycle transfers mem_rdata and retires the single outstanding request.
  fetch_state_t      r_state, w_next;
  logic              r_front, r_req, r_under;
  logic [CNT_W-1:0]  r_fr_cnt, r_bk_cnt, r_idx;
  logic [ADDR_W-1:0] r_bk_base, r_addr;

  logic [CNT_W-1:0]  w_nl_cnt;
  logic              w_nl_en, w_bk_en, w_ack, w_last, w_pending, w_start_en;
  logic [ADDR_W-1:0] w_start_base;
  logic              w_load, w_we, w_adv, w_set_under, w_req_next;

  assign w_nl_cnt     = fetch_en ? clamp_words(line_words, MAX_WORDS) : '0;
  assign w_nl_en      = (w_nl_cnt != '0);
  assign w_bk_en      = (r_bk_cnt != '0);
  assign w_ack        = mem_ack & r_req;
  assign w_last       = (r_idx == r_bk_cnt - CNT_W'(1));
  assign w_pending    = r_req & ~w_ack;
  assign w_start_en   = new_line ? w_nl_en : w_bk_en;
  assign w_start_base = new_line ? base_addr : r_bk_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (new_line && w_nl_en) w_next = ST_FETCH;
      ST_FETCH: begin
        if (new_line)            w_next = w_pending ? ST_DRAIN : (w_nl_en ? ST_FETCH : ST_IDLE);
        else if (w_ack && w_last) w_next = ST_IDLE;
      end
      ST_DRAIN: if (w_ack) w_next = w_start_en ? ST_FETCH : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_we        = 1'b0;
    w_adv       = 1'b0;
    w_set_under = 1'b0;
    w_req_next  = r_req;
    case (r_state)
      ST_IDLE: begin
        w_load     = new_line & w_nl_en;
        w_req_next = w_load;
      end
      ST_FETCH: begin
        w_we        = w_ack;
        w_set_under = new_line & ~(w_ack & w_last);
        if (new_line) begin
          w_load     = ~w_pending & w_nl_en;
          w_req_next = w_pending | w_load;
        end else if (w_ack) begin
          w_adv      = ~w_last;
          w_req_next = 1'b0;
        end else begin
          w_req_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        // The acked word belongs to an abandoned line and is dropped.
        w_set_under = new_line;
        w_load      = w_ack & w_start_en;
        w_req_next  = w_ack ? w_load : 1'b1;
      end
      default: w_req_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_idx     <= '0;
      r_under   <= 1'b0;
      r_front   <= 1'b0;
      r_fr_cnt  <= '0;
      r_bk_cnt  <= '0;
      r_bk_base <= '0;
    end else begin
      r_req <= w_req_next;
      if (w_load) begin
        r_addr <= w_start_base;
        r_idx  <= '0;
      end else if (w_adv) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_idx != CNT_W'(MAX_WORDS - 1)) r_idx <= r_idx + CNT_W'(1);
      end
      if (w_set_under) r_under <= 1'b1;
      if (new_line) begin
        r_front   <= ~r_front;
        r_fr_cnt  <= r_bk_cnt;
        r_bk_base <= base_addr;
        r_bk_cnt  <= w_nl_cnt;
      end
    end
  end

  // Display side: active-clock counter, launch decode, two-stage pixel pipe.
  logic              r_hb_d, r_l1_v, r_l1_lo, r_l1_z, r_pix_v;
  logic [7:0]        r_pix;
  logic [ACT_W-1:0]  r_act;
  logic [ACT_W-1:0]  w_act, w_k;
  logic [CNT_W-1:0]  w_word;
  logic              w_launch, w_zero;
  logic [RAM_AW-1:0] w_waddr, w_raddr;
  logic [15:0]       w_rdata;

  assign w_act    = (~hblank & r_hb_d) ? '0 : r_act;
  assign w_launch = ~hblank & (cm ? (w_act[0] == 1'b0) : (w_act[1:0] == 2'b00));
  assign w_k      = cm ? (w_act >> 1) : (w_act >> 2);
  assign w_word   = w_k[CNT_W:1];
  assign w_zero   = (w_k >= ACT_W'({r_fr_cnt, 1'b0}));
  assign w_raddr  = (r_front ? RAM_AW'(MAX_WORDS) : '0) + RAM_AW'(w_word);
  assign w_waddr  = (r_front ? '0 : RAM_AW'(MAX_WORDS)) + RAM_AW'(r_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hb_d  <= 1'b1;
      r_act   <= '0;
      r_l1_v  <= 1'b0;
      r_l1_lo <= 1'b0;
      r_l1_z  <= 1'b0;
      r_pix_v <= 1'b0;
      r_pix   <= '0;
    end else begin
      r_hb_d <= hblank;
      if (!hblank && w_act != '1) r_act <= w_act + ACT_W'(1);
      r_l1_v  <= w_launch;
      r_l1_lo <= w_k[0];
      r_l1_z  <= w_zero;
      r_pix_v <= r_l1_v;
      if (r_l1_v) r_pix <= r_l1_z ? 8'h00 : (r_l1_lo ? w_rdata[7:0] : w_rdata[15:8]);
    end
  end

  line_ram #(
    .DEPTH (RAM_D),
    .AW    (RAM_AW),
    .DW    (16)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (mem_rdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign mem_req     = r_req;
  assign mem_addr    = r_addr;
  assign underrun    = r_under;
  assign pix         = r_pix;
  assign pix_valid   = r_pix_v;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_video_line_fetch.sv
// Scenario bench for video_line_fetch with a behavioural memory and line model.
module tb_video_line_fetch;
  import video_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n, new_line, hblank, cm, fetch_en;
  logic [20:0]  base_addr;
  logic [8:0]   line_words;
  logic         mem_req;
  logic [20:0]  mem_addr;
  logic         mem_ack;
  logic [15:0]  mem_rdata;
  logic [7:0]   pix;
  logic         pix_valid, underrun;
  fetch_state_t dbg_state;

  video_line_fetch dut (
    .clk(clk), .reset_n(reset_n), .new_line(new_line), .hblank(hblank), .cm(cm),
    .fetch_en(fetch_en), .base_addr(base_addr), .line_words(line_words),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pix(pix), .pix_valid(pix_valid), .underrun(underrun), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory model: acks after ack_delay cycles of continuous request.
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [15:0] mem_over [int];
  logic [20:0] acc_q[$];
  int          acc_t[$];

  function automatic logic [15:0] mem_word(input logic [20:0] a);
    if (mem_over.exists(int'(a))) return mem_over[int'(a)];
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req && wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
      acc_q.push_back(mem_addr);
      acc_t.push_back(cyc);
      wait_cnt  = 0;
    end else begin
      mem_ack = 1'b0;
      if (mem_req) wait_cnt++;
    end
  end

  // Line model: words expected in each bank, swapped on every new_line.
  logic [15:0] front_q[$], back_q[$];
  bit          front_ok = 1'b1, back_ok = 1'b1;

  task automatic pulse_new_line(input bit en, input logic [20:0] base, input int words);
    int n;
    @(negedge clk);
    new_line   = 1'b1;
    fetch_en   = en;
    base_addr  = base;
    line_words = 9'(words);
    front_q    = back_q;
    front_ok   = back_ok;
    back_q.delete();
    n = en ? ((words > MAX_WORDS) ? MAX_WORDS : words) : 0;
    for (int i = 0; i < n; i++) back_q.push_back(mem_word(base + 21'(i)));
    back_ok = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (dbg_state != ST_IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (dbg_state == ST_IDLE);
  endtask

  int          rl_bad_j;
  logic [7:0]  rl_got, rl_exp;

  // Streams one active line; returns strobe count and count of timing/value misses.
  task automatic run_line(input int n_active, input bit cmode, output int strobes, output int bad);
    int   period, k;
    bit   exp_v;
    logic [7:0]  exp_p;
    logic [15:0] w;
    period  = cmode ? 2 : 4;
    cm      = cmode;
    strobes = 0;
    bad     = 0;
    for (int j = 0; j < n_active + 4; j++) begin
      @(negedge clk);
      exp_v = (j >= 2) && (((j - 2) % period) == 0) && ((j - 2) < n_active);
      k     = (j - 2) / period;
      if (pix_valid === 1'b1) strobes++;
      if (pix_valid !== exp_v) begin
        if (bad == 0) begin rl_bad_j = j; rl_got = {7'd0, pix_valid}; rl_exp = {7'd0, exp_v}; end
        bad++;
      end else if (exp_v && front_ok) begin
        exp_p = 8'h00;
        if (k < 2 * front_q.size()) begin
          w     = front_q[k / 2];
          exp_p = k[0] ? w[7:0] : w[15:8];
        end
        if (pix !== exp_p) begin
          if (bad == 0) begin rl_bad_j = j; rl_got = pix; rl_exp = exp_p; end
          bad++;
        end
      end
      hblank = (j < n_active) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; new_line = 1'b0; hblank = 1'b1; cm = 1'b1; fetch_en = 1'b0;
    base_addr = '0; line_words = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 21'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (pix !== 8'h00) begin errors++; $display("FAIL reset_pix: got %h want 00", pix); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_fill();
    bit ok;
    ack_delay = 0;
    acc_q.delete(); acc_t.delete();
    pulse_new_line(1'b1, 21'h01000, 4);
    wait_idle(100, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL fill_idle: state=%0d want IDLE", dbg_state); end
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL fill_count: got %0d want 4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== 21'h01000 + 21'(i)) begin
        errors++; $display("FAIL fill_addr[%0d]: got %h want %h", i, acc_q[i], 21'h01000 + 21'(i));
      end
    end
    for (int i = 0; i + 1 < acc_t.size(); i++) begin
      checks++;
      if (acc_t[i+1] - acc_t[i] !== 2) begin
        errors++; $display("FAIL fill_gap[%0d]: got %0d cycles want 2", i, acc_t[i+1] - acc_t[i]);
      end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL fill_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_display();
    bit ok;
    int s, b;
    mem_over[32'h2000] = 16'hA1B2;
    mem_over[32'h2001] = 16'hC3D4;
    pulse_new_line(1'b1, 21'h02000, 2);
    wait_idle(100, ok);
    pulse_new_line(1'b0, 21'h0, 0);
    run_line(16, 1'b1, s, b);
    checks++; if (!ok) begin errors++; $display("FAIL disp_fetch_idle: state=%0d want IDLE", dbg_state); end
    checks++; if (s !== 8) begin errors++; $display("FAIL disp_strobes: got %0d want 8", s); end
    checks++;
    if (b !== 0) begin
      errors++; $display("FAIL disp_pix: %0d misses, first at sample %0d got %h want %h", b, rl_bad_j, rl_got, rl_exp);
    end
  endtask

  task automatic test_cm0();
    bit ok;
    int s, b, n;
    logic [20:0] b1, b2;
    b1 = 21'($urandom_range(0, 32'h1F0000));
    b2 = 21'($urandom_range(0, 32'h1F0000));
    pulse_new_line(1'b1, b1, $urandom_range(100, 384));
    wait_idle(1000, ok);
    pulse_new_line(1'b1, b2, $urandom_range(50, 300));
    run_line(1536, 1'b0, s, b);
    checks++; if (s !== 384) begin errors++; $display("FAIL cm0_strobes: got %0d want 384", s); end
    checks++;
    if (b !== 0) begin
      errors++; $display("FAIL cm0_pix: %0d misses, first at sample %0d got %h want %h", b, rl_bad_j, rl_got, rl_exp);
    end
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cm0_fetch_idle: state=%0d want IDLE", dbg_state); end
    pulse_new_line(1'b0, 21'h0, 0);
    n = $urandom_range(200, 1536);
    run_line(n, 1'b1, s, b);
    checks++; if (s !== (n + 1) / 2) begin errors++; $display("FAIL cm1_rand_strobes: got %0d want %0d", s, (n + 1) / 2); end
    checks++;
    if (b !== 0) begin
      errors++; $display("FAIL cm1_rand_pix: %0d misses, first at sample %0d got %h want %h", b, rl_bad_j, rl_got, rl_exp);
    end
  endtask

  task automatic test_underrun();
    bit ok, held_bad;
    logic [20:0] b1, b2;
    b1 = 21'h0A000;
    b2 = 21'h0B000;
    ack_delay = 2000;
    acc_q.delete(); acc_t.delete();
    pulse_new_line(1'b1, b1, 3);
    repeat (10) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== b1) begin
      errors++; $display("FAIL ur_pending: req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, b1);
    end
    pulse_new_line(1'b1, b2, 2);
    front_ok = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", underrun); end
    checks++; if (dbg_state !== ST_DRAIN) begin errors++; $display("FAIL ur_state: got %0d want DRAIN", dbg_state); end
    held_bad = 1'b0;
    for (int i = 0; i < 2100 && acc_q.size() == 0; i++) begin
      @(negedge clk);
      if (acc_q.size() == 0 && (mem_req !== 1'b1 || mem_addr !== b1)) held_bad = 1'b1;
    end
    ack_delay = 0;
    wait_idle(200, ok);
    checks++; if (held_bad) begin errors++; $display("FAIL ur_hold: req/addr changed before ack, want req=1 addr=%h", b1); end
    checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL ur_count: got %0d want 3", acc_q.size()); end
    if (acc_q.size() == 3) begin
      checks++; if (acc_q[0] !== b1) begin errors++; $display("FAIL ur_addr0: got %h want %h", acc_q[0], b1); end
      checks++; if (acc_q[1] !== b2) begin errors++; $display("FAIL ur_addr1: got %h want %h", acc_q[1], b2); end
      checks++; if (acc_q[2] !== b2 + 21'd1) begin errors++; $display("FAIL ur_addr2: got %h want %h", acc_q[2], b2 + 21'd1); end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ur_idle: state=%0d want IDLE", dbg_state); end
  endtask

  task automatic test_clamp_idle();
    bit ok;
    int s, b, n_req;
    logic [20:0] b3;
    b3 = 21'h10000;
    acc_q.delete(); acc_t.delete();
    pulse_new_line(1'b1, b3, 500);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_idle: state=%0d want IDLE", dbg_state); end
    checks++; if (acc_q.size() !== 384) begin errors++; $display("FAIL clamp_count: got %0d want 384", acc_q.size()); end
    if (acc_q.size() == 384) begin
      checks++;
      if (acc_q[383] !== b3 + 21'd383) begin errors++; $display("FAIL clamp_last: got %h want %h", acc_q[383], b3 + 21'd383); end
    end
    pulse_new_line(1'b0, 21'h0, 0);
    n_req = acc_q.size();
    run_line(1536, 1'b1, s, b);
    checks++; if (s !== 768) begin errors++; $display("FAIL clamp_strobes: got %0d want 768", s); end
    checks++;
    if (b !== 0) begin
      errors++; $display("FAIL clamp_pix: %0d misses, first at sample %0d got %h want %h", b, rl_bad_j, rl_got, rl_exp);
    end
    pulse_new_line(1'b0, 21'h0, 0);
    run_line(1536, 1'b1, s, b);
    checks++; if (s !== 768) begin errors++; $display("FAIL idle_strobes: got %0d want 768", s); end
    checks++;
    if (b !== 0) begin
      errors++; $display("FAIL idle_zero_pix: %0d misses, first at sample %0d got %h want %h", b, rl_bad_j, rl_got, rl_exp);
    end
    checks++; if (acc_q.size() !== n_req) begin errors++; $display("FAIL idle_no_req: got %0d requests want %0d", acc_q.size(), n_req); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_async_reset();
    ack_delay = 100;
    pulse_new_line(1'b1, 21'h30000, 8);
    repeat (5) @(negedge clk);
    checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL ar_pre_state: got %0d want FETCH", dbg_state); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ar_sticky_underrun: got %b want 1", underrun); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ar_mem_req: got %b want 0", mem_req); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL ar_pix_valid: got %b want 0", pix_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ar_underrun: got %b want 0", underrun); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL ar_state: got %0d want IDLE", dbg_state); end
    repeat (2) @(negedge clk);
    ack_delay = 0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_display();
    test_cm0();
    test_underrun();
    test_clamp_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_line_fetch.md
VIDEO_LINE_FETCH -- requirements
Module: video_line_fetch

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 384, meaning line buffer bank depth in 16-bit words (768 pixels at 8 bpp).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port new_line, input, 1, one-clock end-of-line pulse from video timing.
REQ-005 SHALL have port hblank, input, 1, registered horizontal blank from video timing.
REQ-006 SHALL have port cm, input, 1, color mode; 0 = 4 clocks per pixel, 1 = 2 clocks per pixel.
REQ-007 SHALL have port fetch_en, input, 1, meaning the line following the next new_line is displayed.
REQ-008 SHALL have port base_addr, input, 21, word address of the next line's pixel data.
REQ-009 SHALL have port line_words, input, 9, number of words for the next line.
REQ-010 SHALL have port mem_req, output, 1, memory read request.
REQ-011 SHALL have port mem_addr, output, 21, word address of the request.
REQ-012 SHALL have port mem_ack, input, 1, request accepted; mem_rdata is valid in this cycle.
REQ-013 SHALL have port mem_rdata, input, 16, read word; the high byte is the earlier pixel.
REQ-014 SHALL have port pix, output, 8, CLUT index.
REQ-015 SHALL have port pix_valid, output, 1, a one-clock strobe marking a new pix.
REQ-016 SHALL have port underrun, output, 1, sticky flag: a fetch was incomplete at swap time.

Function
REQ-017 SHALL use two banks, front and back. Front is read for display; back is filled by the fetch FSM.
REQ-018 SHALL, on each new_line: swap banks, then latch base_addr, min(line_words, MAX_WORDS) and fetch_en for the new back bank.
REQ-019 SHALL implement FSM states IDLE, FETCH, DRAIN:
  - IDLE to FETCH on new_line with fetch_en=1 and latched count>0.
  - FETCH to IDLE after the last ack.
REQ-020 SHALL, in FETCH, hold mem_req=1 with mem_addr stable until mem_ack. It writes mem_rdata to back[word_idx], increments the address, and re-requests on the next cycle. There is at most one outstanding request.
REQ-021 SHALL, when new_line arrives in FETCH:
  - set underrun;
  - if no request is pending, restart immediately with the new parameters;
  - otherwise enter DRAIN, keep mem_req until ack, discard that data, then restart with the parameters latched at that new_line.
REQ-022 SHALL perform no memory requests for a line with fetch_en=0 or count 0. That bank SHALL read as all-zero pixels.
REQ-023 SHALL run an active clock counter that resets to 0 on the first cycle with hblank=0 after hblank=1, and increments while hblank=0.
REQ-024 SHALL define pixel k as launched when the counter equals k*(cm?2:4). Byte k is read from front[k/2], high byte first when k is even.
REQ-025 SHALL present pix with pix_valid=1 exactly 2 clocks after launch: one cycle of RAM read, one output register.
REQ-026 SHALL output pix=0 with pix_valid still strobing for bytes at or beyond 2*count of the front bank.
REQ-027 SHALL cap word_idx at MAX_WORDS-1; the count clamp guarantees no wrap.
REQ-028 SHALL keep the swapped-in parameters when new_line and mem_ack coincide in FETCH: the ack's data is written to the old back bank, now front. Underrun is set if that was not the last word.
REQ-029 SHALL clear underrun only by reset.

Reset
REQ-030 SHALL drive these values while reset_n=0:
  - mem_req=0, mem_addr=0, pix=0, pix_valid=0, underrun=0;
  - FSM IDLE, front bank 0, counts 0.
REQ-031 SHALL abandon any transaction in flight on reset, with mem_req dropping immediately. The memory side tolerates this.

Structure
REQ-032 SHALL place MAX_WORDS, the FSM state enum and the address width in shared package video_pkg.
REQ-033 SHALL use one sub-module, line_ram: a simple dual-port RAM with 2*MAX_WORDS x 16, registered read, and one write plus one read port.

Verification
REQ-034 SHALL test basic fill. Stimulus: fetch_en=1, base=0x01000, words=4, immediate ack. Response: 4 requests at 0x01000..0x01003, mem_req gaps of one cycle, FSM back in IDLE.
REQ-035 SHALL test display. Stimulus: cm=1, front holds 0xA1B2,0xC3D4. Response: pix A1,B2,C3,D4 at 2,4,6,8 clocks after hblank falls, then 0x00 for later bytes.
REQ-036 SHALL test cm=0. Response: pix_valid period of 4 clocks; 384 strobes per 1536-clock active line.
REQ-037 SHALL test underrun with drain. Stimulus: ack delayed 2000 clocks, new_line while req is pending. Response: underrun=1, mem_req held until ack, and the next request is at the newly latched base.
REQ-038 SHALL test clamp and idle lines. Stimulus: words=500, then fetch_en=0. Response: exactly 384 requests, then no requests and an all-zero line.
REQ-039 SHALL test async reset. Stimulus: reset_n low mid-FETCH, between clock edges. Response: mem_req, pix_valid and underrun are 0 before the next edge.
